// File: rtl/uart_rx.sv
// UART receiver: 8N1, MSB first, mid-bit sampling with a one-cycle valid pulse.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit.
module uart_rx #(
    parameter int CLK_FREQ     = 48000,
    parameter int BAUD         = 9600,
    parameter int BAUD_DIVIDOR = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_err
);

    localparam logic [15:0] LAST_C = 16'(BAUD_DIVIDOR - 1);
    localparam logic [15:0] MID_C  = 16'(BAUD_DIVIDOR / 2);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] DEC_C  = MID_C + 16'd1;
`else
    localparam logic [15:0] DEC_C  = MID_C;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [3:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shreg_reg, shreg_next;
    logic [7:0]  data_reg, data_next;
    logic        valid_reg, valid_next;
    logic        ferr_reg, ferr_next;
    logic        sync1_reg, sync2_reg, prev_reg;
    logic        rxd_s;
    logic        sample;
    logic        at_dec, at_last;
    logic [15:0] cnt_step;

    assign rxd_s = sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The first two votes are captured here; the third is rxd_s live at MID+1.
    logic maj_a_reg, maj_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_a_reg <= 1'b1;
            maj_b_reg <= 1'b1;
        end else begin
            if (cnt_reg == MID_C - 16'd1)
                maj_a_reg <= rxd_s;
            if (cnt_reg == MID_C)
                maj_b_reg <= rxd_s;
        end
    end

    assign sample = (maj_a_reg & maj_b_reg) | (maj_a_reg & rxd_s) | (maj_b_reg & rxd_s);
`else
    assign sample = rxd_s;
`endif

    assign at_dec   = (cnt_reg == DEC_C);
    assign at_last  = (cnt_reg == LAST_C);
    assign cnt_step = at_last ? 16'd0 : cnt_reg + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 16'd0;
            bit_idx_reg <= 4'd0;
            shreg_reg   <= 8'h00;
            data_reg    <= 8'h00;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shreg_reg   <= shreg_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shreg_next   = shreg_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = 16'd0;
                // Edge, not level: a held-low line (break) never restarts a frame.
                if (prev_reg && !rxd_s)
                    state_next = START;
            end
            START: begin
                cnt_next = cnt_step;
                if (at_dec && sample) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else if (at_last) begin
                    state_next   = DATA;
                    bit_idx_next = 4'd0;
                end
            end
            DATA: begin
                cnt_next = cnt_step;
                if (at_dec)
                    shreg_next = {shreg_reg[6:0], sample};
                if (at_last) begin
                    if (bit_idx_reg == 4'd7)
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx_reg + 4'd1;
                end
            end
            STOP: begin
                cnt_next = cnt_step;
                // Leaving at mid-stop leaves half a bit to catch the next start edge.
                if (at_dec) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                    if (sample) begin
                        data_next  = shreg_reg;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_frame_err = ferr_reg;
    assign rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: line-level decoding model plus per-cycle output compare.
module tb_uart_rx;

    localparam int DIV = 5;
    localparam int MID = DIV / 2;
    localparam int NB  = 10 * DIV;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC     = MID + 1;
    localparam int LAT_LIT = 51;
`else
    localparam int DEC     = MID;
    localparam int LAT_LIT = 50;
`endif
    localparam int LAT = 9 * DIV + DEC + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;

    uart_rx #(.CLK_FREQ(48000), .BAUD(9600)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {int edge_n; bit err; logic [7:0] data;} exp_t;
    typedef struct {int lo; int hi;} win_t;
    exp_t exp_q[$];
    win_t busy_q[$];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_data = 8'h00;
    bit         check_en = 1'b0;
    int         last_valid_edge = -1;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         busy_rise = -1;
    logic       busy_d = 1'b0;
    int         last_e0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    always begin : compare
        bit ev, ee, eb;
        @(posedge clk);
        #1;
        if (check_en) begin
            ev = 1'b0;
            ee = 1'b0;
            eb = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].edge_n == edge_cnt) begin
                    ev = !exp_q[i].err;
                    ee = exp_q[i].err;
                    if (!exp_q[i].err)
                        model_data = exp_q[i].data;
                    exp_q.delete(i);
                    break;
                end
            end
            foreach (busy_q[i])
                if (edge_cnt >= busy_q[i].lo && edge_cnt <= busy_q[i].hi)
                    eb = 1'b1;
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, ev});
            chk("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, ee});
            chk("rx_busy", {31'd0, rx_busy}, {31'd0, eb});
            chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
        end
        if (rx_valid) begin
            last_valid_edge = edge_cnt;
            valid_cnt++;
            $display("rx byte %02h at edge %0d", rx_data, edge_cnt);
        end
        if (rx_frame_err) begin
            err_cnt++;
            $display("rx framing error at edge %0d", edge_cnt);
        end
        if (rx_busy && !busy_d)
            busy_rise = edge_cnt;
        busy_d = rx_busy;
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // vec[k] is the line level seen by the k-th clock edge of the frame.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int glitch, input bit track);
        logic [NB-1:0] vec;
        logic [9:0]    s;
        logic [7:0]    byte_exp;
        int            e0, p;
        for (int k = 0; k < NB; k++) begin
            if (k / DIV == 0)
                vec[k] = 1'b0;
            else if (k / DIV == 9)
                vec[k] = stop;
            else
                vec[k] = d[8 - k / DIV];
        end
        if (glitch >= 0)
            vec[glitch] = ~vec[glitch];
        for (int b = 0; b < 10; b++) begin
            p = DIV * b + MID + 1;
`ifdef UART_RX_MAJORITY_EN
            s[b] = (vec[p-1] & vec[p]) | (vec[p-1] & vec[p+1]) | (vec[p] & vec[p+1]);
`else
            s[b] = vec[p];
`endif
        end
        for (int i = 0; i < 8; i++)
            byte_exp[7 - i] = s[i + 1];
        e0 = edge_cnt + 1;
        last_e0 = e0;
        if (track) begin
            exp_q.push_back('{e0 + LAT, !s[9], byte_exp});
            busy_q.push_back('{e0 + 2, e0 + LAT - 1});
        end
        $display("tx frame %02h stop=%0b glitch=%0d start edge %0d", d, stop, glitch, e0);
        for (int k = 0; k < NB; k++) begin
            rxd = vec[k];
            @(negedge clk);
        end
    endtask

    initial begin : stim
        int v0, f0, e0;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset rx_busy", {31'd0, rx_busy}, 32'd0);
        chk("reset rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_en = 1'b1;
        idle(5);

        // Single frame with literal latency and data
        send_frame(8'hA5, 1'b1, -1, 1'b1);
        e0 = last_e0;
        idle(10);
        chk("a5 latency", last_valid_edge - e0, LAT_LIT);
        chk("a5 busy rise", busy_rise - e0, 32'd2);
        chk("a5 data", {24'd0, rx_data}, 32'hA5);

        // Back-to-back frames, no idle gap
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, -1, 1'b1);
        send_frame(8'hFF, 1'b1, -1, 1'b1);
        send_frame(8'h3C, 1'b1, -1, 1'b1);
        idle(10);
        chk("b2b count", valid_cnt - v0, 32'd3);
        chk("b2b last data", {24'd0, rx_data}, 32'h3C);

        // Transmitter-style pair with a short gap
        send_frame(8'h81, 1'b1, -1, 1'b1);
        idle(7);
        send_frame(8'h7E, 1'b1, -1, 1'b1);
        idle(10);
        chk("loop data", {24'd0, rx_data}, 32'h7E);

        // False start
        v0 = valid_cnt;
        f0 = err_cnt;
        e0 = edge_cnt + 1;
        busy_q.push_back('{e0 + 2, e0 + 2 + DEC});
        $display("tx false start at edge %0d", e0);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        chk("false start busy rise", busy_rise - e0, 32'd2);
        chk("false start no valid", valid_cnt - v0, 32'd0);
        chk("false start no err", err_cnt - f0, 32'd0);

        // Framing error followed by a break, then recovery
        send_frame(8'h12, 1'b1, -1, 1'b1);
        f0 = err_cnt;
        send_frame(8'h55, 1'b0, -1, 1'b1);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        chk("ferr count", err_cnt - f0, 32'd1);
        chk("ferr data kept", {24'd0, rx_data}, 32'h12);
        idle(10);
        send_frame(8'h99, 1'b1, -1, 1'b1);
        idle(10);
        chk("after break data", {24'd0, rx_data}, 32'h99);

        // Reset in the middle of the data bits of an all-ones frame
        check_en = 1'b0;
        $display("tx partial frame ff with reset");
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset rx_data", {24'd0, rx_data}, 32'h00);
        chk("midreset rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midreset rx_busy", {31'd0, rx_busy}, 32'd0);
        chk("midreset rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_data = 8'h00;
        exp_q.delete();
        busy_q.delete();
        repeat (6 * DIV) @(negedge clk);
        check_en = 1'b1;
        idle(5);
        send_frame(8'hC3, 1'b1, -1, 1'b1);
        idle(10);
        chk("after reset data", {24'd0, rx_data}, 32'hC3);

        // One-cycle glitch at the mid sample of byte bit 3
        send_frame(8'h5A, 1'b1, DIV * 5 + MID + 1, 1'b1);
        idle(10);
`ifdef UART_RX_MAJORITY_EN
        chk("glitch data", {24'd0, rx_data}, 32'h5A);
`else
        chk("glitch data", {24'd0, rx_data}, 32'h52);
`endif

        check_en = 1'b0;
        chk("queue drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
